// File: rtl/prt_dump_uart_tx.sv
// Snapshots the four prtregs probe words on a trigger and sends them as a framed 8N1 UART stream.
// Optional XOR checksum byte appended when PRT_DUMP_CHKSUM_EN is defined.
module prt_dump_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] prtregs1_i,
  input  logic [31:0] prtregs2_i,
  input  logic [31:0] prtregs3_i,
  input  logic [31:0] prtregs4_i,
  input  logic        trigger_i,
  output logic        uart_txd_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef PRT_DUMP_CHKSUM_EN
  localparam logic [4:0] LAST_BYTE = 5'd17;
`else
  localparam logic [4:0] LAST_BYTE = 5'd16;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_reg, state_next;
  logic [BAUD_W-1:0]   baud_reg, baud_next;
  logic [2:0]          bit_reg, bit_next;
  logic [4:0]          byte_reg, byte_next;
  logic [127:0]        snap_reg, snap_next;
  logic                txd_reg, txd_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic [7:0]          frame_bytes [0:31];
  logic [7:0]          cur_byte;
  logic [2:0]          bit_inc;
  logic                baud_wrap;

  genvar gi;

  // Byte 0 is the sync marker; bytes 1..16 are the snapshot, most significant byte first.
  assign frame_bytes[0] = 8'hA5;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_data
      assign frame_bytes[gi+1] = snap_reg[127-8*gi -: 8];
    end
  endgenerate

`ifdef PRT_DUMP_CHKSUM_EN
  logic [7:0] chk_reg, chk_next;
  assign frame_bytes[17] = chk_reg;
  generate
    for (gi = 18; gi < 32; gi++) begin : g_pad
      assign frame_bytes[gi] = 8'h00;
    end
  endgenerate
`else
  generate
    for (gi = 17; gi < 32; gi++) begin : g_pad
      assign frame_bytes[gi] = 8'h00;
    end
  endgenerate
`endif

  assign cur_byte  = frame_bytes[byte_reg];
  assign bit_inc   = bit_reg + 3'd1;
  assign baud_wrap = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      snap_reg  <= '0;
      txd_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef PRT_DUMP_CHKSUM_EN
      chk_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      snap_reg  <= snap_next;
      txd_reg   <= txd_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
`ifdef PRT_DUMP_CHKSUM_EN
      chk_reg   <= chk_next;
`endif
    end
  end

  // Outputs are the registered next values, so each bit starts on the edge that enters it.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    snap_next  = snap_reg;
    txd_next   = txd_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
`ifdef PRT_DUMP_CHKSUM_EN
    chk_next   = chk_reg;
`endif
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (trigger_i) begin
          state_next = START;
          snap_next  = {prtregs1_i, prtregs2_i, prtregs3_i, prtregs4_i};
          byte_next  = '0;
          bit_next   = '0;
          txd_next   = 1'b0;
          busy_next  = 1'b1;
`ifdef PRT_DUMP_CHKSUM_EN
          chk_next   = '0;
`endif
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_next  = '0;
          state_next = DATA;
          bit_next   = '0;
          txd_next   = cur_byte[0];
`ifdef PRT_DUMP_CHKSUM_EN
          if (byte_reg != 5'd0 && byte_reg != LAST_BYTE)
            chk_next = chk_reg ^ cur_byte;
`endif
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_next = '0;
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_next = bit_inc;
            txd_next = cur_byte[bit_inc];
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_next = '0;
          if (byte_reg < LAST_BYTE) begin
            state_next = START;
            byte_next  = byte_reg + 5'd1;
            txd_next   = 1'b0;
          end else begin
            state_next = IDLE;
            txd_next   = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else begin
          baud_next = baud_reg + BAUD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign uart_txd_o = txd_reg;
  assign busy_o     = busy_reg;
  assign done_o     = done_reg;

endmodule

// File: tb/tb_prt_dump_uart_tx.sv
// Directed bench for prt_dump_uart_tx: decodes the serial line at bit midpoints and
// compares against hand-written frames, plus reset, busy-trigger and held-trigger sequences.
module tb_prt_dump_uart_tx;

  localparam int CPB = 4;
`ifdef PRT_DUMP_CHKSUM_EN
  localparam int NB = 18;
`else
  localparam int NB = 17;
`endif
  localparam int F = NB * 10 * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic [31:0] r1 = '0, r2 = '0, r3 = '0, r4 = '0;
  logic        txd, busy, done;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  prt_dump_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .prtregs1_i (r1),
    .prtregs2_i (r2),
    .prtregs3_i (r3),
    .prtregs4_i (r4),
    .trigger_i  (trigger),
    .uart_txd_o (txd),
    .busy_o     (busy),
    .done_o     (done)
  );

  typedef struct {
    string        name;
    logic [31:0]  r1, r2, r3, r4;
    logic [135:0] exp_bytes;
    logic [7:0]   exp_chk;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs(input vec_t v);
    r1 = v.r1; r2 = v.r2; r3 = v.r3; r4 = v.r4;
  endtask

  // Trigger, follow the frame to edge T+F, decode every byte and check the end-of-frame pulse.
  task automatic run_frame(input string tag, input logic [143:0] exp_frame,
                           input int mod_at, input int trig_a, input int trig_b);
    logic [9:0] sym [NB];
    int busy_bad;
    int done_bad;
    int bidx;
    busy_bad = 0;
    done_bad = 0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    check({tag, "_start_txd"}, {31'd0, txd}, 32'd0);
    check({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
    for (int j = 0; j < F; j++) begin
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_bad++;
      if (j % CPB == CPB / 2) begin
        bidx = j / CPB;
        sym[bidx / 10][bidx % 10] = txd;
      end
      if (j == mod_at) begin
        r1 = 32'hDEADBEEF; r2 = 32'hDEADBEEF; r3 = 32'hDEADBEEF; r4 = 32'hDEADBEEF;
      end
      if (j == trig_a - 1 || j == trig_b - 1) trigger = 1'b1;
      if (j == trig_a || j == trig_b) trigger = 1'b0;
      tick();
    end
    trigger = 1'b0;
    check({tag, "_busy_cycles_low"}, busy_bad, 0);
    check({tag, "_early_done_cycles"}, done_bad, 0);
    for (int n = 0; n < NB; n++)
      check($sformatf("%s_byte%0d", tag, n), {22'd0, sym[n]},
            {22'd0, 1'b1, exp_frame[143-8*n -: 8], 1'b0});
    check({tag, "_done_at_F"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_at_F"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check({tag, "_idle_bad_cycles"}, bad, 0);
  endtask

  initial begin
    vecs[0] = '{"basic", 32'h12345678, 32'h9ABCDEF0, 32'h00000001, 32'hFFFFFFFF,
                136'hA5_12345678_9ABCDEF0_00000001_FFFFFFFF, 8'h01};
    vecs[1] = '{"zeros", 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                136'hA5_00000000_00000000_00000000_00000000, 8'h00};
    vecs[2] = '{"mixed", 32'hA5A5A5A5, 32'h01020304, 32'h80402010, 32'h0F0F0F0F,
                136'hA5_A5A5A5A5_01020304_80402010_0F0F0F0F, 8'hF4};

    // Reset idle
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("reset_hold%0d", c), {29'd0, txd, busy, done}, {29'd0, 3'b100});
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("reset_idle%0d", c), {29'd0, txd, busy, done}, {29'd0, 3'b100});
    end

    // Table-driven frames
    for (int v = 0; v < 3; v++) begin
      load_regs(vecs[v]);
      run_frame(vecs[v].name, {vecs[v].exp_bytes, vecs[v].exp_chk}, -1, -1, -1);
      idle_check(vecs[v].name, 2 * CPB);
    end

    // Snapshot hold: inputs change from edge T+5 on
    load_regs(vecs[0]);
    run_frame("snap", {vecs[0].exp_bytes, vecs[0].exp_chk}, 4, -1, -1);
    idle_check("snap", 2 * CPB);

    // Triggers mid-frame and on the done edge are ignored
    load_regs(vecs[2]);
    run_frame("busytrig", {vecs[2].exp_bytes, vecs[2].exp_chk}, -1, 100, F);
    idle_check("busytrig", 3 * CPB);

    // Held trigger: back-to-back frames with a single idle cycle
    begin
      int d1, d2, s2;
      d1 = -1; d2 = -1; s2 = -1;
      load_regs(vecs[0]);
      trigger = 1'b1;
      tick();
      for (int c = 0; c < 3 * F; c++) begin
        if (done === 1'b1) begin
          if (d1 < 0) d1 = c;
          else d2 = c;
        end
        if (d1 >= 0 && s2 < 0 && c > d1 && busy === 1'b1 && txd === 1'b0) s2 = c;
        if (d2 >= 0) break;
        tick();
      end
      trigger = 1'b0;
      check("held_first_done", d1, F);
      check("held_second_start", s2, F + 1);
      check("held_done_spacing", d2 - d1, F + 1);
      idle_check("held", 3 * CPB);
    end

    // Reset mid-frame abandons the frame
    begin
      int done_cnt, busy_cnt;
      done_cnt = 0; busy_cnt = 0;
      load_regs(vecs[2]);
      trigger = 1'b1;
      tick();
      trigger = 1'b0;
      for (int j = 0; j < 199; j++) tick();
      check("rst_mid_pre_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      tick();
      tick();
      check("rst_mid_txd", {31'd0, txd}, 32'd1);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      for (int c = 0; c < F; c++) begin
        tick();
        if (done !== 1'b0) done_cnt++;
        if (busy !== 1'b0) busy_cnt++;
      end
      check("rst_mid_no_done", done_cnt, 0);
      check("rst_mid_stays_idle", busy_cnt, 0);
      load_regs(vecs[1]);
      run_frame("after_rst", {vecs[1].exp_bytes, vecs[1].exp_chk}, -1, -1, -1);
      idle_check("after_rst", 2 * CPB);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
